// File: rtl/l3l4cs_gen_pkg.sv
// l3l4cs_gen_pkg: shared types and constants for the l3l4cs transmit checksum generator
package l3l4cs_gen_pkg;
  typedef enum logic [2:0] {IDLE, HDR, FOLD, EMIT, PAY} state_t;
  localparam logic [3:0] IPV4_VER = 4'd4;
  localparam logic [3:0] IHL_MIN = 4'd5;
  localparam logic [3:0] CSUM_WORD_IDX = 4'd2;
  typedef struct packed {
    logic [15:0] csum;
    logic        hdr_len_err;
    logic        ver_err;
    logic        len_err;
  } status_t;
endpackage

// File: rtl/l3l4cs_csum16_acc.sv
// l3l4cs_csum16_acc: ones'-complement accumulator of 16-bit halves with two-stage fold and invert
module l3l4cs_csum16_acc (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        add,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [20:0] acc,
  output logic [15:0] csum
);
  logic [16:0] f1;
  logic [15:0] f2;
  always_ff @(posedge clk) begin
    if (reset) acc <= '0;
    else if (clr || add) acc <= (clr ? 21'd0 : acc) + (add ? {5'd0, a} + {5'd0, b} : 21'd0);
  end
  // 21 bits hold 30 halves; after the first fold the carry is at most one bit
  always_comb begin
    f1 = {1'b0, acc[15:0]} + {12'd0, acc[20:16]};
    f2 = f1[15:0] + {15'd0, f1[16]};
    csum = ~f2;
  end
endmodule

// File: rtl/l3l4cs_ipv4_csum_gen.sv
// l3l4cs_ipv4_csum_gen: buffers the IPv4 header, inserts its RFC 1071 checksum and forwards the packet.
// Optional total-length check enabled by L3L4CS_GEN_TOTLEN_CHK_EN.
module l3l4cs_ipv4_csum_gen
  import l3l4cs_gen_pkg::*;
#(
  parameter int HDR_DEPTH = 15,
  parameter int DATA_WD = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_WD-1:0] s_data,
  input  logic [3:0]         s_keep,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DATA_WD-1:0] m_data,
  output logic [3:0]         m_keep,
  output logic               m_last,
  output logic               cs_valid_o,
  output logic [15:0]        l3_csum_o,
  output logic               hdr_len_error_o,
  output logic               version_error_o,
  output logic               length_error_o
);
  state_t state, nxt;
  logic [DATA_WD-1:0] hbuf [HDR_DEPTH];
  logic [3:0] cnt, rd, ihl_eff, last_idx, last_keep, widx;
  logic ended, trunc, ver_err, ihl_err, len_err, modify;
  logic s_hs, m_hs, done, hdr_end, emit_last, buf_wr;
  logic [20:0] acc;
  logic [15:0] csum, csum_r;
  status_t st;
  assign s_hs = s_valid && s_ready;
  assign m_hs = m_valid && m_ready;
  assign done = m_hs && m_last;
  assign buf_wr = s_hs && (state == IDLE || state == HDR);
  assign widx = (state == IDLE) ? 4'd0 : cnt;
  assign hdr_end = s_hs && (state == IDLE ? s_last : state == HDR && (s_last || cnt == ihl_eff - 4'd1));
  assign emit_last = ended && rd == last_idx;
  assign modify = !(ver_err || ihl_err || trunc);
  l3l4cs_csum16_acc u_acc (
    .clk(clk),
    .reset(reset),
    .clr(state == IDLE && s_hs),
    .add(buf_wr),
    .a(s_data[31:16]),
    .b((state == HDR && cnt == CSUM_WORD_IDX) ? 16'd0 : s_data[15:0]),
    .acc(acc),
    .csum(csum)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = s_hs ? (s_last ? FOLD : HDR) : IDLE;
      HDR: nxt = hdr_end ? FOLD : HDR;
      FOLD: nxt = EMIT;
      EMIT: nxt = (m_hs && rd == last_idx) ? (ended ? IDLE : PAY) : EMIT;
      PAY: nxt = done ? IDLE : PAY;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    s_ready = (state == IDLE || state == HDR) ? 1'b1 : state == PAY ? m_ready : 1'b0;
    m_valid = state == EMIT ? 1'b1 : state == PAY ? s_valid : 1'b0;
    m_data = state == EMIT ? ((rd == CSUM_WORD_IDX && modify) ? {hbuf[rd][31:16], csum_r} : hbuf[rd])
           : state == PAY ? s_data : '0;
    m_keep = state == EMIT ? (emit_last ? last_keep : 4'hF) : state == PAY ? s_keep : 4'h0;
    m_last = state == EMIT ? emit_last : state == PAY ? s_last : 1'b0;
  end
  always_ff @(posedge clk) if (buf_wr) hbuf[widx] <= s_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rd <= '0;
      ihl_eff <= IHL_MIN;
      last_idx <= '0;
      last_keep <= '0;
      ended <= 1'b0;
      trunc <= 1'b0;
      ver_err <= 1'b0;
      ihl_err <= 1'b0;
      csum_r <= '0;
      st <= '0;
      cs_valid_o <= 1'b0;
    end else begin
      state <= nxt;
      cs_valid_o <= done;
      if (buf_wr) cnt <= widx + 4'd1;
      if (state == IDLE && s_hs) begin
        ihl_eff <= (s_data[27:24] < IHL_MIN) ? IHL_MIN : s_data[27:24];
        ihl_err <= s_data[27:24] < IHL_MIN;
        ver_err <= s_data[31:28] != IPV4_VER;
        ended <= 1'b0;
        trunc <= 1'b0;
      end
      // s_last before the final header word means a truncated header
      if (hdr_end) begin
        ended <= s_last;
        trunc <= s_last && !(state == HDR && cnt == ihl_eff - 4'd1);
        last_idx <= widx;
        last_keep <= s_keep;
      end
      if (state == FOLD) begin
        csum_r <= modify ? csum : 16'd0;
        rd <= '0;
      end
      if (state == EMIT && m_hs) rd <= rd + 4'd1;
      if (done) st <= '{csum: csum_r, hdr_len_err: ihl_err || trunc, ver_err: ver_err, len_err: len_err};
    end
  end
`ifdef L3L4CS_GEN_TOTLEN_CHK_EN
  logic [15:0] nbytes, totlen, pop;
  assign pop = 16'($countones(s_keep));
  always_ff @(posedge clk) begin
    if (reset) begin
      nbytes <= '0;
      totlen <= '0;
      len_err <= 1'b0;
    end else if (s_hs) begin
      nbytes <= (state == IDLE ? 16'd0 : nbytes) + pop;
      if (state == IDLE) totlen <= s_data[15:0];
      if (s_last) len_err <= ((state == IDLE ? 16'd0 : nbytes) + pop) != (state == IDLE ? s_data[15:0] : totlen);
    end
  end
`else
  assign len_err = 1'b0;
`endif
  assign l3_csum_o = st.csum;
  assign hdr_len_error_o = st.hdr_len_err;
  assign version_error_o = st.ver_err;
  assign length_error_o = st.len_err;
endmodule
